// File: rtl/pic_seq_pkg.sv
// Shared opcode decode constants and sequencer state type for the 12-bit PIC fetch path.
package pic_seq_pkg;

   localparam int unsigned INST_W = 12;

   localparam logic [INST_W-1:0] NOP         = 12'h000;
   localparam logic [INST_W-1:0] GOTO_MASK   = 12'hE00;
   localparam logic [INST_W-1:0] GOTO_MATCH  = 12'hA00;
   localparam logic [INST_W-1:0] CALL_MASK   = 12'hF00;
   localparam logic [INST_W-1:0] CALL_MATCH  = 12'h900;
   localparam logic [INST_W-1:0] RETLW_MASK  = 12'hF00;
   localparam logic [INST_W-1:0] RETLW_MATCH = 12'h800;
   localparam logic [INST_W-1:0] SLEEP_MASK  = 12'hFFF;
   localparam logic [INST_W-1:0] SLEEP_MATCH = 12'h003;

   typedef enum logic [1:0] {
      ST_RST = 2'd0,
      ST_RUN = 2'd1,
      ST_SLP = 2'd2
   } seq_state_t;

   function automatic logic op_hit(input logic [INST_W-1:0] inst,
                                   input logic [INST_W-1:0] mask,
                                   input logic [INST_W-1:0] match);
      return (inst & mask) == match;
   endfunction

endpackage

// File: rtl/pic_call_stack.sv
// Two-entry shift call stack with saturating pointer and sticky over/underflow flag.
module pic_call_stack #(
   parameter int unsigned PC_W  = 11,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] ret_addr,
   output logic [PC_W-1:0] top,
   output logic            err
);

   localparam int unsigned SP_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0] stk0;
   logic [PC_W-1:0] stk1;
   logic [SP_W-1:0] sp;

   assign top = stk0;

   // Push drops the oldest entry when full; pop at empty returns the stale top.
   always_ff @(posedge clk) begin
      if (rst) begin
         stk0 <= '0;
         stk1 <= '0;
         sp   <= '0;
         err  <= 1'b0;
      end else if (push) begin
         stk1 <= stk0;
         stk0 <= ret_addr;
         if (sp == SP_W'(DEPTH)) err <= 1'b1;
         else                    sp  <= sp + SP_W'(1);
      end else if (pop) begin
         stk0 <= stk1;
         if (sp == SP_W'(0)) err <= 1'b1;
         else                sp  <= sp - SP_W'(1);
      end
   end

endmodule

// File: rtl/pic_fetch_seq.sv
// Fetch/execute sequencer: owns PC, execute-stage instruction register and call stack.
module pic_fetch_seq
   import pic_seq_pkg::*;
#(
   parameter int unsigned    PC_W      = 11,
   parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b1}},
   parameter int unsigned    STK_DEPTH = 2
) (
   input  logic              clock_c,
   input  logic              reset_c,
   input  logic [11:0]       rom_data,
   input  logic              rom_ready,
   output logic              rom_req,
   output logic [PC_W-1:0]   rom_addr,
   output logic [11:0]       inst_q,
   output logic              inst_valid,
   input  logic              skip,
   input  logic              pcl_we,
   input  logic [7:0]        pcl_data,
   input  logic              wake,
   output logic [PC_W-1:0]   pc,
   output logic              sleeping,
   output logic              stack_err
);

   seq_state_t      state;
   logic            skip_pend;
   logic            is_goto;
   logic            is_call;
   logic            is_retlw;
   logic            is_sleep;
   logic            in_run;
   logic            do_redirect;
   logic            skip_eff;
   logic            stk_push;
   logic            stk_pop;
   logic [PC_W-1:0] stk_top;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_inc;

   assign rom_addr = pc;
   assign in_run   = (state == ST_RUN);
   assign skip_eff = skip | skip_pend;
   assign pc_inc   = pc + PC_W'(1);

   // Execute-stage decode and redirect target; opcode targets outrank a PCL write.
   always_comb begin
      is_goto  = 1'b0;
      is_call  = 1'b0;
      is_retlw = 1'b0;
      is_sleep = 1'b0;
      if (inst_valid) begin
         is_goto  = op_hit(inst_q, GOTO_MASK,  GOTO_MATCH);
         is_call  = op_hit(inst_q, CALL_MASK,  CALL_MATCH);
         is_retlw = op_hit(inst_q, RETLW_MASK, RETLW_MATCH);
         is_sleep = op_hit(inst_q, SLEEP_MASK, SLEEP_MATCH);
      end
      do_redirect = in_run && (is_goto || is_call || is_retlw || pcl_we);
      stk_push    = in_run && is_call;
      stk_pop     = in_run && is_retlw;
      target      = {pc[PC_W-1:8], pcl_data};
      if (is_goto)       target = {pc[PC_W-1:9], inst_q[8:0]};
      else if (is_call)  target = {pc[PC_W-1:9], 1'b0, inst_q[7:0]};
      else if (is_retlw) target = stk_top;
   end

   pic_call_stack #(
      .PC_W  (PC_W),
      .DEPTH (STK_DEPTH)
   ) u_stack (
      .clk      (clock_c),
      .rst      (reset_c),
      .push     (stk_push),
      .pop      (stk_pop),
      .ret_addr (pc),
      .top      (stk_top),
      .err      (stack_err)
   );

   // Sequencer state, PC and instruction register.
   always_ff @(posedge clock_c) begin
      if (reset_c) begin
         state      <= ST_RST;
         pc         <= RESET_VEC;
         inst_q     <= NOP;
         inst_valid <= 1'b0;
         rom_req    <= 1'b0;
         sleeping   <= 1'b0;
         skip_pend  <= 1'b0;
      end else begin
         case (state)
            ST_RST: begin
               state   <= ST_RUN;
               rom_req <= 1'b1;
            end
            ST_RUN: begin
               if (do_redirect) begin
                  pc         <= target;
                  inst_q     <= NOP;
                  inst_valid <= 1'b0;
                  skip_pend  <= 1'b0;
               end else if (is_sleep) begin
                  state      <= ST_SLP;
                  rom_req    <= 1'b0;
                  sleeping   <= 1'b1;
                  inst_q     <= NOP;
                  inst_valid <= 1'b0;
               end else if (skip_eff) begin
                  // A skip is only retired once it has swallowed a real fetched word.
                  inst_q     <= NOP;
                  inst_valid <= 1'b0;
                  if (rom_ready) begin
                     pc        <= pc_inc;
                     skip_pend <= 1'b0;
                  end else begin
                     skip_pend <= 1'b1;
                  end
               end else if (!rom_ready) begin
                  inst_q     <= NOP;
                  inst_valid <= 1'b0;
               end else begin
                  inst_q     <= rom_data;
                  inst_valid <= 1'b1;
                  pc         <= pc_inc;
               end
            end
            ST_SLP: begin
               if (wake) begin
                  state    <= ST_RUN;
                  rom_req  <= 1'b1;
                  sleeping <= 1'b0;
               end
            end
            default: begin
               state <= ST_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pic_fetch_seq.sv
// Scoreboard bench: expected executed words are queued by the stimulus, popped by a monitor.
module tb_pic_fetch_seq;

   localparam int unsigned PC_W = 11;

   logic            clock_c = 1'b0;
   logic            reset_c = 1'b1;
   logic [11:0]     rom_data;
   logic            rom_ready = 1'b1;
   logic            rom_req;
   logic [PC_W-1:0] rom_addr;
   logic [11:0]     inst_q;
   logic            inst_valid;
   logic            skip = 1'b0;
   logic            pcl_we = 1'b0;
   logic [7:0]      pcl_data = 8'h00;
   logic            wake = 1'b0;
   logic [PC_W-1:0] pc;
   logic            sleeping;
   logic            stack_err;

   logic [11:0]     rom_mem [0:2047];

   typedef struct packed {
      logic [11:0]     inst;
      logic [PC_W-1:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   assign rom_data = rom_mem[rom_addr];

   pic_fetch_seq #(.PC_W(PC_W)) dut (
      .clock_c    (clock_c),
      .reset_c    (reset_c),
      .rom_data   (rom_data),
      .rom_ready  (rom_ready),
      .rom_req    (rom_req),
      .rom_addr   (rom_addr),
      .inst_q     (inst_q),
      .inst_valid (inst_valid),
      .skip       (skip),
      .pcl_we     (pcl_we),
      .pcl_data   (pcl_data),
      .wake       (wake),
      .pc         (pc),
      .sleeping   (sleeping),
      .stack_err  (stack_err)
   );

   initial forever #5 clock_c = ~clock_c;

   // Monitor: every executed (valid) word must match the head of the expectation queue.
   initial forever begin
      @(negedge clock_c);
      if (!reset_c && inst_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL exec_unexpected: got inst=%03h pc=%03h, required none", inst_q, pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (inst_q !== e.inst || pc !== e.pc) begin
               bad++;
               $display("FAIL exec: got inst=%03h pc=%03h, required inst=%03h pc=%03h",
                        inst_q, pc, e.inst, e.pc);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clock_c);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, want);
      end
   endtask

   task automatic expect_exec(input logic [11:0] i, input logic [PC_W-1:0] p);
      exp_t e;
      e.inst = i;
      e.pc   = p;
      exp_q.push_back(e);
   endtask

   task automatic fill_rom();
      for (int a = 0; a < 2048; a++) rom_mem[a] = {4'h4, 8'(a)};
   endtask

   task automatic do_reset();
      reset_c   = 1'b1;
      rom_ready = 1'b1;
      skip      = 1'b0;
      pcl_we    = 1'b0;
      wake      = 1'b0;
      step();
      step();
      reset_c = 1'b0;
   endtask

   task automatic wait_inst(input string name, input logic [11:0] w, input logic [PC_W-1:0] p);
      int n = 0;
      while (!(inst_valid === 1'b1 && inst_q === w && pc === p) && n < 300) begin
         step();
         n++;
      end
      total++;
      if (n >= 300) begin
         bad++;
         $display("FAIL %s: timeout waiting for inst=%03h pc=%03h, last inst=%03h pc=%03h",
                  name, w, p, inst_q, pc);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d expected words never executed, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      // GOTO out of the reset vector, pc wraps 7FF -> 000
      fill_rom();
      rom_mem[11'h7FF] = 12'hA05;
      do_reset();
      chk("rst_pc",        32'(pc),         32'h7FF);
      chk("rst_inst_q",    32'(inst_q),     32'h000);
      chk("rst_valid",     32'(inst_valid), 32'h0);
      chk("rst_rom_req",   32'(rom_req),    32'h0);
      chk("rst_sleeping",  32'(sleeping),   32'h0);
      chk("rst_stack_err", 32'(stack_err),  32'h0);
      expect_exec(12'hA05, 11'h000);
      expect_exec(12'h405, 11'h006);
      expect_exec(12'h406, 11'h007);
      step();
      chk("rst_nofetch_pc", 32'(pc),         32'h7FF);
      chk("run_rom_req",    32'(rom_req),    32'h1);
      chk("rst_nofetch_v",  32'(inst_valid), 32'h0);
      wait_inst("goto_seen", 12'hA05, 11'h000);
      step();
      chk("goto_bubble", 32'(inst_valid), 32'h0);
      chk("goto_pc",     32'(pc),         32'h005);
      drain("goto_drain");

      // CALL 0x010 from 0x020, RETLW back to 0x021
      fill_rom();
      rom_mem[11'h7FF] = 12'hA20;
      rom_mem[11'h020] = 12'h910;
      rom_mem[11'h010] = 12'h8AB;
      do_reset();
      expect_exec(12'hA20, 11'h000);
      expect_exec(12'h910, 11'h021);
      expect_exec(12'h8AB, 11'h011);
      expect_exec(12'h421, 11'h022);
      expect_exec(12'h422, 11'h023);
      wait_inst("call_seen", 12'h910, 11'h021);
      step();
      chk("call_bubble", 32'(inst_valid), 32'h0);
      chk("call_pc",     32'(pc),         32'h010);
      wait_inst("ret_seen", 12'h8AB, 11'h011);
      step();
      chk("ret_bubble", 32'(inst_valid), 32'h0);
      chk("ret_pc",     32'(pc),         32'h021);
      drain("call_drain");
      chk("call_stack_err", 32'(stack_err), 32'h0);

      // Three nested CALLs overflow, then three RETLWs including one at empty
      fill_rom();
      rom_mem[11'h7FF] = 12'hA40;
      rom_mem[11'h040] = 12'h950;
      rom_mem[11'h050] = 12'h960;
      rom_mem[11'h060] = 12'h970;
      rom_mem[11'h070] = 12'h8C1;
      rom_mem[11'h061] = 12'h8C2;
      rom_mem[11'h051] = 12'h8C3;
      do_reset();
      expect_exec(12'hA40, 11'h000);
      expect_exec(12'h950, 11'h041);
      expect_exec(12'h960, 11'h051);
      expect_exec(12'h970, 11'h061);
      expect_exec(12'h8C1, 11'h071);
      expect_exec(12'h8C2, 11'h062);
      expect_exec(12'h8C3, 11'h052);
      wait_inst("call2_seen", 12'h960, 11'h051);
      step();
      chk("call2_no_err", 32'(stack_err), 32'h0);
      wait_inst("call3_seen", 12'h970, 11'h061);
      step();
      chk("ovf_err", 32'(stack_err), 32'h1);
      chk("ovf_pc",  32'(pc),        32'h070);
      wait_inst("pop1_seen", 12'h8C1, 11'h071);
      step();
      chk("pop1_pc", 32'(pc), 32'h061);
      wait_inst("pop3_seen", 12'h8C3, 11'h052);
      step();
      chk("unf_pc",  32'(pc),        32'h051);
      chk("unf_err", 32'(stack_err), 32'h1);
      drain("stack_drain");

      // Skip with ROM ready, then skip held pending across a stall
      fill_rom();
      rom_mem[11'h7FF] = 12'hA30;
      rom_mem[11'h030] = 12'h000;
      rom_mem[11'h034] = 12'h000;
      do_reset();
      expect_exec(12'hA30, 11'h000);
      expect_exec(12'h000, 11'h031);
      expect_exec(12'h432, 11'h033);
      expect_exec(12'h433, 11'h034);
      expect_exec(12'h000, 11'h035);
      expect_exec(12'h436, 11'h037);
      expect_exec(12'h437, 11'h038);
      wait_inst("skip_nop", 12'h000, 11'h031);
      skip = 1'b1;
      step();
      skip = 1'b0;
      chk("skip_bubble", 32'(inst_valid), 32'h0);
      chk("skip_pc",     32'(pc),         32'h032);
      wait_inst("skip2_nop", 12'h000, 11'h035);
      skip      = 1'b1;
      rom_ready = 1'b0;
      step();
      skip      = 1'b0;
      rom_ready = 1'b1;
      chk("pend_bubble", 32'(inst_valid), 32'h0);
      chk("pend_pc",     32'(pc),         32'h035);
      step();
      chk("pend_drop_v",  32'(inst_valid), 32'h0);
      chk("pend_drop_pc", 32'(pc),         32'h036);
      drain("skip_drain");

      // SLEEP, wake ignored while SLEEP executes, then wake resumes at held pc
      fill_rom();
      rom_mem[11'h7FF] = 12'hA80;
      rom_mem[11'h080] = 12'h003;
      do_reset();
      expect_exec(12'hA80, 11'h000);
      expect_exec(12'h003, 11'h081);
      expect_exec(12'h481, 11'h082);
      expect_exec(12'h482, 11'h083);
      wait_inst("sleep_seen", 12'h003, 11'h081);
      wake = 1'b1;
      step();
      wake = 1'b0;
      chk("slp_sleeping", 32'(sleeping),   32'h1);
      chk("slp_rom_req",  32'(rom_req),    32'h0);
      chk("slp_valid",    32'(inst_valid), 32'h0);
      repeat (3) step();
      chk("slp_pc_held",  32'(pc),       32'h081);
      chk("slp_still",    32'(sleeping), 32'h1);
      wake = 1'b1;
      step();
      wake = 1'b0;
      chk("wake_sleeping", 32'(sleeping), 32'h0);
      chk("wake_rom_req",  32'(rom_req),  32'h1);
      chk("wake_pc",       32'(pc),       32'h081);
      drain("sleep_drain");

      // PCL write redirect, then PCL write losing to a coincident GOTO
      fill_rom();
      rom_mem[11'h7FF] = 12'hBF5;
      rom_mem[11'h13E] = 12'hA50;
      do_reset();
      expect_exec(12'hBF5, 11'h000);
      expect_exec(12'h4F5, 11'h1F6);
      expect_exec(12'h43C, 11'h13D);
      expect_exec(12'h43D, 11'h13E);
      expect_exec(12'hA50, 11'h13F);
      expect_exec(12'h450, 11'h051);
      expect_exec(12'h451, 11'h052);
      wait_inst("pcl_at", 12'h4F5, 11'h1F6);
      pcl_we   = 1'b1;
      pcl_data = 8'h3C;
      step();
      pcl_we = 1'b0;
      chk("pcl_bubble", 32'(inst_valid), 32'h0);
      chk("pcl_pc",     32'(pc),         32'h13C);
      wait_inst("pcl_goto", 12'hA50, 11'h13F);
      pcl_we   = 1'b1;
      pcl_data = 8'h99;
      step();
      pcl_we = 1'b0;
      chk("pcl_vs_goto_pc", 32'(pc), 32'h050);
      drain("pcl_drain");

      // Reset while a CALL executes: no push survives, stack pointer back to empty
      fill_rom();
      rom_mem[11'h7FF] = 12'hA20;
      rom_mem[11'h020] = 12'h910;
      rom_mem[11'h010] = 12'h8AB;
      do_reset();
      expect_exec(12'hA20, 11'h000);
      expect_exec(12'h910, 11'h021);
      expect_exec(12'hA10, 11'h000);
      expect_exec(12'h8AB, 11'h011);
      expect_exec(12'h400, 11'h001);
      wait_inst("midcall_seen", 12'h910, 11'h021);
      reset_c = 1'b1;
      rom_mem[11'h7FF] = 12'hA10;
      step();
      chk("midrst_pc",      32'(pc),         32'h7FF);
      chk("midrst_valid",   32'(inst_valid), 32'h0);
      chk("midrst_rom_req", 32'(rom_req),    32'h0);
      chk("midrst_err",     32'(stack_err),  32'h0);
      reset_c = 1'b0;
      wait_inst("midrst_ret", 12'h8AB, 11'h011);
      step();
      chk("midrst_ret_pc",  32'(pc),        32'h000);
      chk("midrst_ret_err", 32'(stack_err), 32'h1);
      drain("midrst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pic_fetch_seq.md
Name: pic_fetch_seq

Overview:
- Fetch/execute sequencer for the 12-bit PIC-style core; sits between program ROM and ins_decode.
- Owns the PC, the instruction register feeding ins_decode, and the 2-level call stack.
- Resolves GOTO/CALL/RETLW/PCL writes, decoder skips, ROM stalls and SLEEP/wake.
- Fetch of instruction N+1 overlaps execute of N; every redirect or skip costs one NOP bubble.

Parameters:
- PC_W, 11, program counter / ROM address width (min 10)
- RESET_VEC, {PC_W{1'b1}}, PC value after reset
- STK_DEPTH, 2, call stack entries (fixed at 2 in this revision)

Ports:
- clock_c  in  1  single clock, rising edge
- reset_c  in  1  synchronous, active-high reset
- rom_data  in  12  program word for rom_addr
- rom_ready  in  1  rom_data valid this cycle
- rom_req  out  1  fetch request
- rom_addr  out  PC_W  equals pc (combinational)
- inst_q  out  12  execute-stage instruction to ins_decode
- inst_valid  out  1  inst_q is a real fetched word, not a bubble
- skip  in  1  from the execute path: skip next instruction (valid while inst_q executes)
- pcl_we  in  1  execute stage writes PCL
- pcl_data  in  8  new PCL value
- wake  in  1  wake from SLEEP (level)
- pc  out  PC_W  current fetch address
- sleeping  out  1  high in SLP
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (sync, reset_c=1 at edge): pc=RESET_VEC, inst_q=12'h000 (NOP), inst_valid=0, state=RST, sp=0, stack entries=0, stack_err=0, sleeping=0, rom_req=0. Reset wins over every other event, mid-operation included.
- States: RST, RUN, SLP.
- RST -> RUN unconditionally after one cycle; no fetch in RST.
- rom_req=1 only in RUN.
- Opcode decode, gated by inst_valid: GOTO inst_q[11:9]=3'b101; CALL inst_q[11:8]=4'b1001; RETLW inst_q[11:8]=4'b1000; SLEEP inst_q=12'h003.
- Priority each RUN cycle: redirect (GOTO/CALL/RETLW/pcl_we) > SLEEP > skip > ROM stall > normal.
- Normal (rom_ready=1): inst_q<=rom_data, inst_valid<=1, pc<=pc+1, wrapping modulo 2^PC_W.
- Stall (rom_ready=0, no higher event): inst_q<=NOP, inst_valid<=0, pc holds.
- GOTO: pc<={pc[PC_W-1:9], inst_q[8:0]}.
- CALL: push pc; pc<={pc[PC_W-1:9], 1'b0, inst_q[7:0]}.
- RETLW: pc<=pop.
- pcl_we: pc<={pc[PC_W-1:8], pcl_data}. If pcl_we coincides with GOTO/CALL/RETLW, the opcode target wins.
- Any redirect: the word fetched this cycle is discarded (inst_q<=NOP, inst_valid<=0) regardless of rom_ready. Fetch resumes at the target next cycle.
- Skip: word fetched this cycle discarded as NOP; pc<=pc+1 only if rom_ready=1, else pc holds and the skip is held pending until a word is consumed. A skip while a pending skip is outstanding merges with it (single skip).
- SLEEP in inst_q: state<=SLP, inst_q<=NOP, inst_valid<=0, pc holds; sleeping=1 from the next cycle.
- SLP: wake sampled only in SLP. wake=1 -> RUN next cycle, fetch resumes at the held pc. Wake during the cycle SLEEP executes is ignored.
- Stack push: stk1<=stk0, stk0<=ret. At sp=2 the oldest entry is lost and stack_err<=1; sp saturates at 2.
- Stack pop: return stk0, stk0<=stk1. At sp=0 return stk0 (stale) and set stack_err<=1; sp floors at 0.
- stack_err clears only on reset.
- Latency: a word presented with rom_ready=1 appears on inst_q the next cycle. Branch penalty is exactly one bubble.

Decomposition:
- pic_seq_pkg holds:
  - opcode masks/match values for GOTO, CALL, RETLW, SLEEP
  - NOP constant 12'h000
  - state enum {RST, RUN, SLP}
- Sub-module pic_call_stack: 2-entry shift stack with push/pop/ret_addr/sp/err. pic_fetch_seq owns all sequencing.

Test Plan:
- Reset then rom_ready=1, ROM[7FF]=12'hA05 (GOTO 0x005) -> inst_q=A05 at cycle 2, then one NOP bubble (inst_valid=0), pc=0x005, next inst_q=ROM[005].
- CALL 0x010 at pc 0x020 (ROM[020]=12'h910), ROM[010]=12'h8AB (RETLW) -> pc 0x010, sp=1, then return to pc=0x021 with one bubble each way, stack_err=0.
- Three nested CALLs without return -> stack_err=1 after the third. RETLW at sp=0 -> stack_err stays 1, pc=stale stk0.
- skip=1 while inst_q=12'h000 at pc=0x031 -> word from 0x031 replaced by NOP, pc=0x032. Repeat with rom_ready=0 that cycle -> skip held pending, next valid word dropped.
- SLEEP (12'h003) executes -> sleeping=1, rom_req=0, pc frozen. wake=1 -> RUN next cycle, first fetch at frozen pc.
- pcl_we=1, pcl_data=8'h3C at pc=0x1F5 -> pc=0x13C after one bubble. reset_c=1 mid-CALL -> pc=RESET_VEC, sp=0, inst_valid=0.
